// File: rtl/sracc.sv
// sracc: streaming single-precision accumulator for same-sign groups of words.
// Wraps the combinational sradd magnitude adder on the acc->acc path.
// Optional build macro: SRACC_SIGN_CHECK_EN (discard and flag opposite-sign words).

// sradd: adds the magnitudes of a and b, result carries a's sign; truncating.
module sradd (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        ovf
);
    logic [30:0] big;
    logic [30:0] sml;
    logic [7:0]  e_big;
    logic [7:0]  e_sml;
    logic [7:0]  shamt;
    logic [23:0] m_big;
    logic [23:0] m_sml;
    logic [23:0] m_sml_sh;
    logic [24:0] msum;
    logic [8:0]  exp9;
    logic [22:0] frac;

    // Align the smaller operand to the larger one, add, renormalise by one bit.
    always_comb begin
        big      = a[30:0];
        sml      = b[30:0];
        if (b[30:0] > a[30:0]) begin
            big = b[30:0];
            sml = a[30:0];
        end
        e_big    = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        e_sml    = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        m_big    = {(big[30:23] != 8'd0), big[22:0]};
        m_sml    = {(sml[30:23] != 8'd0), sml[22:0]};
        shamt    = e_big - e_sml;
        m_sml_sh = (shamt >= 8'd24) ? 24'd0 : (m_sml >> shamt);
        msum     = {1'b0, m_big} + {1'b0, m_sml_sh};
        if (msum[24]) begin
            exp9 = {1'b0, e_big} + 9'd1;
            frac = msum[23:1];
        end else begin
            exp9 = msum[23] ? {1'b0, e_big} : 9'd0;
            frac = msum[22:0];
        end
        ovf = (exp9 >= 9'd255);
        sum = {a[31], exp9[7:0], frac};
    end
endmodule

module sracc #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [DATA_W-1:0] ACC_NAN = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              accept_c;
    logic [DATA_W-1:0] add_sum_c;
    logic              add_ovf_c;

    assign accept_c = in_valid && in_ready_q;

    sradd u_sradd (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum_c),
        .ovf (add_ovf_c)
    );

    // Next-state, accumulator, counter and error update.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    acc_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = in_last ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (accept_c) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (acc_q[30:0] == 31'd0) begin
                        acc_d = in_data;
                    end else if (in_data[30:0] == 31'd0) begin
                        acc_d = acc_q;
                    end
`ifdef SRACC_SIGN_CHECK_EN
                    else if (in_data[31] != acc_q[31]) begin
                        err_d = 1'b1;
                    end
`endif
                    else if ((acc_q == ACC_NAN) || add_ovf_c) begin
                        acc_d = ACC_NAN;
                        err_d = 1'b1;
                    end else begin
                        acc_d = add_sum_c;
                    end
                    if (in_last) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = (state_d == S_HOLD);
        in_ready_d  = (state_d != S_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_err   = err_q;
endmodule

// File: tb/tb_sracc.sv
// Testbench for sracc: directed vector table, corner sequences, random groups
// against an integer-magnitude reference model.
module tb_sracc;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    int passed = 0;
    int total  = 0;

    sracc #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic [31:0] exp_d;
        int          exp_c;
        logic        exp_e;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add_vec(input logic [31:0] d, input logic last,
                           input logic [31:0] ed, input int ec, input logic ee);
        vec_t v;
        v.d = d; v.last = last; v.exp_d = ed; v.exp_c = ec; v.exp_e = ee;
        tbl.push_back(v);
    endtask

    // Integer magnitude (< 2^24) to single-precision bits, exact.
    function automatic logic [31:0] mkf(input logic s, input int unsigned m);
        int p;
        logic [31:0] sh;
        if (m == 0) return {s, 31'd0};
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        sh = m << (23 - p);
        return {s, 8'(127 + p), sh[22:0]};
    endfunction

    // Present one word at a negedge; returns at the negedge after it was taken.
    task automatic push(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Called right after the last word was taken; holds out_ready low for dly cycles.
    task automatic collect(input string name, input logic [31:0] ed, input int ec,
                           input logic ee, input int dly);
        logic [31:0] d0;
        chk({name, "_valid_t1"}, 32'(out_valid), 32'd1);
        d0 = out_data;
        for (int i = 0; i < dly; i++) begin
            chk({name, "_rdy_hold"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            chk({name, "_valid_hold"}, 32'(out_valid), 32'd1);
            chk({name, "_data_stable"}, out_data, d0);
        end
        chk({name, "_data"}, out_data, ed);
        chk({name, "_count"}, 32'(out_count), 32'(ec));
        chk({name, "_err"}, 32'(out_err), 32'(ee));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_rdy_after"}, 32'(in_ready), 32'd1);
        chk({name, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic        m_s, w_s, base_s;
        int unsigned m_mag, w_mag, m_cnt, n;
        logic        m_err;
        logic [31:0] w;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Directed table: basic sum, sign handling, overflow, recovery, zeros.
        add_vec(32'h3f800000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'h3f800000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'h40000000, 1'b1, 32'h40800000, 3, 1'b0);
        add_vec(32'h3f800000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'hbf800000, 1'b0, 32'h0, 0, 1'b0);
`ifdef SRACC_SIGN_CHECK_EN
        add_vec(32'h3f800000, 1'b1, 32'h40000000, 3, 1'b1);
`else
        add_vec(32'h3f800000, 1'b1, 32'h40400000, 3, 1'b0);
`endif
        add_vec(32'h7f000000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'h7f000000, 1'b1, 32'hffffffff, 2, 1'b1);
        add_vec(32'h3f800000, 1'b1, 32'h3f800000, 1, 1'b0);
        add_vec(32'h7f000000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'h7f000000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'h3f800000, 1'b1, 32'hffffffff, 3, 1'b1);
        add_vec(32'h00000000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'h80000000, 1'b0, 32'h0, 0, 1'b0);
        add_vec(32'h40400000, 1'b1, 32'h40400000, 3, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            push(tbl[i].d, tbl[i].last);
            if (tbl[i].last)
                collect($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_c, tbl[i].exp_e, 0);
        end

        // Single word with back-pressure for 5 cycles.
        push(32'hc0400000, 1'b1);
        collect("bp", 32'hc0400000, 1, 1'b0, 5);

        // Count saturation.
        for (int i = 0; i < 300; i++) push(32'h00000000, (i == 299));
        collect("sat", 32'h00000000, 255, 1'b0, 0);

        // Reset mid-group discards it.
        push(32'h40000000, 1'b0);
        push(32'h40000000, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("rstmid_valid2", 32'(out_valid), 32'd0);
        push(32'h3f800000, 1'b1);
        collect("after_rst", 32'h3f800000, 1, 1'b0, 0);

        // Randomized groups of exactly-representable integers.
        for (int g = 0; g < 40; g++) begin
            n = $urandom_range(1, 6);
            base_s = 1'($urandom_range(0, 1));
            m_s = 1'b0; m_mag = 0; m_cnt = 0; m_err = 1'b0;
            for (int k = 0; k < int'(n); k++) begin
                w_mag = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 1000);
                w_s = ($urandom_range(0, 4) == 0) ? ~base_s : base_s;
                w = mkf(w_s, w_mag);
                if (k == 0) begin
                    m_s = w_s; m_mag = w_mag; m_cnt = 1; m_err = 1'b0;
                end else begin
                    m_cnt++;
                    if (m_mag == 0) begin
                        m_s = w_s; m_mag = w_mag;
                    end else if (w_mag == 0) begin
                        m_mag = m_mag;
                    end else if (w_s != m_s) begin
`ifdef SRACC_SIGN_CHECK_EN
                        m_err = 1'b1;
`else
                        m_mag = m_mag + w_mag;
`endif
                    end else begin
                        m_mag = m_mag + w_mag;
                    end
                end
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                push(w, (k == int'(n) - 1));
            end
            collect($sformatf("rnd%0d", g), mkf(m_s, m_mag), int'(m_cnt), m_err,
                    int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sracc.md
# sracc

Streaming single-precision accumulator that sums a group of same-sign IEEE-754 words, one word per cycle, and emits one sum per group. It sits directly around the combinational `sradd` adder. Each cycle it drives the running sum and the incoming word into `sradd`, then registers the result. Groups are delimited by `in_last`; the sum, element count and an error flag leave on a valid/ready output port.

## Interface
- `CNT_W`, default 8: width of the element counter; the count saturates at 2^CNT_W-1.

- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `in_data` and `in_last` are valid.
- `in_ready`, output, 1: block accepts a word this cycle.
- `in_data`, input, 32: SP float element.
- `in_last`, input, 1: this element closes the group.
- `out_valid`, output, 1: group result is held on the output.
- `out_ready`, input, 1: consumer takes the result.
- `out_data`, output, 32: group sum.
- `out_count`, output, CNT_W: number of accepted elements in the group, including discarded ones; saturating.
- `out_err`, output, 1: sticky group error (sign mismatch or overflow).

## Operation
- States:
  - IDLE: accumulator empty.
  - ACC: group open.
  - HOLD: result pending.
- Accept: `in_valid && in_ready`. `in_ready` = (state != HOLD).
- IDLE + accept: `acc <= in_data`, `cnt <= 1`, `err <= 0`. Next state is HOLD if `in_last`, else ACC.
- ACC + accept: `cnt <= sat(cnt+1)`. The update of `acc` depends on the word and the accumulator:
  - If `acc[30:0]==0` (+0 or -0): `acc <= in_data`.
  - Else if `in_data[30:0]==0`: `acc` unchanged.
  - Else if the signs differ and SRACC_SIGN_CHECK_EN is defined: `acc` unchanged and `err <= 1` (element discarded).
  - Otherwise: `acc <= sradd(acc, in_data)`. The result takes `acc`'s sign.
  - In every case, `in_last` moves the state to HOLD.
- Overflow: if the `sradd` result exponent equals 8'hFF, or `acc` is already 32'hFFFFFFFF:
  - `acc <= 32'hFFFFFFFF` and `err <= 1`;
  - later adds in the group leave `acc` at NaN.
- HOLD: `out_valid=1`; `out_data=acc`, `out_count=cnt`, `out_err=err`, all stable until the handshake. `out_valid && out_ready` moves to IDLE.
- Reset values: state IDLE; `acc`=0, `cnt`=0, `err`=0; `out_valid`=0, `out_data`=0, `out_count`=0, `out_err`=0; `in_ready`=1.
- Reset mid-group or in HOLD: the partial group is discarded with no output, and the block resumes in IDLE.

## Timing
- One element per cycle while in IDLE/ACC; no back-pressure inside a group.
- Last element accepted at edge t → `out_valid=1` from t+1.
- Output taken at edge t+k → `in_ready=1` from t+k+1. Each group therefore costs at least one bubble cycle.
- `in_ready` is a function of state only; no combinational path from `out_ready`.
- A single-element group (`in_last` on the first word) gives `out_data=in_data` and `out_count=1`.
- `sradd` sits on the acc→acc path; that path is the single-cycle critical path.

## Configuration
- `SRACC_SIGN_CHECK_EN` defined: an element whose sign differs from a nonzero `acc` is discarded. It still counts, and it sets `out_err`.
- `SRACC_SIGN_CHECK_EN` undefined: no sign compare. The magnitude is added via `sradd` with `acc`'s sign, and `out_err` reflects overflow only.

## Test plan
- 3f800000, 3f800000, 40000000 (last) → out_data 40800000, out_count 3, out_err 0, out_valid one cycle after last accept.
- Single word c0400000 with `in_last`; `out_ready` held low 5 cycles → `in_ready`=0 and the outputs stay constant throughout; the handshake then returns `in_ready`=1 the next cycle.
- 3f800000, bf800000, 3f800000 (last), with SRACC_SIGN_CHECK_EN → 40000000, count 3, err 1. Without the macro → 40400000, count 3, err 0.
- 7f000000, 7f000000 (last) → out_data FFFFFFFF, out_err 1. The next group, 3f800000 (last), → 3f800000, err 0.
- 00000000, 80000000, 40400000 (last) → 40400000, count 3, err 0. Also 300 words of 00000000 with CNT_W=8 → out_count 255.
- Assert `reset` for one cycle after 2 words of a group → no `out_valid`. The next group, 3f800000 (last), → 3f800000, count 1.
